// File: rtl/br_pred.sv
// br_pred: 64-entry branch predictor of 2-bit saturating counters.
// Define BR_PRED_GSHARE_EN to XOR a 6-bit global history into the index.
module br_pred (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc_f,
    input  logic [31:0] ir_f,
    output logic        pr_taken,
    output logic [63:0] pr_addr,
    input  logic        upd_valid,
    input  logic [63:0] upd_pc,
    input  logic        upd_taken,
    input  logic        stall
);

    localparam int unsigned Depth    = 64;
    localparam logic [6:0]  OpBranch = 7'b1100011;
    localparam logic [1:0]  CntInit  = 2'b01;

    logic [1:0]  cnt_q [Depth];
    logic [1:0]  cnt_d [Depth];
    logic [5:0]  idx_f;
    logic [5:0]  idx_u;
    logic        upd_en;
    logic        is_br;
    logic [1:0]  cnt_u;
    logic [1:0]  cnt_n;
    logic [63:0] b_off;
    logic        unused_ok;

    // Only the index bits of upd_pc and the control fields of ir_f matter.
    assign unused_ok = ^{upd_pc[63:8], upd_pc[1:0], ir_f[24:12]};

    // An update is accepted only when the pipeline is not stalled.
    always_comb begin
        upd_en = upd_valid && !stall;
    end

`ifdef BR_PRED_GSHARE_EN
    logic [5:0] ghr_q;
    logic [5:0] ghr_d;

    // Both lookup and update hash the PC with the pre-shift history.
    always_comb begin
        idx_f = pc_f[7:2] ^ ghr_q;
        idx_u = upd_pc[7:2] ^ ghr_q;
    end

    // Shift each accepted outcome into the history.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_en) begin
            ghr_d = {ghr_q[4:0], upd_taken};
        end
    end

    // History register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    // Plain bimodal indexing from the word-aligned PC.
    always_comb begin
        idx_f = pc_f[7:2];
        idx_u = upd_pc[7:2];
    end
`endif

    // Saturating step of the counter being trained.
    always_comb begin
        cnt_u = cnt_q[idx_u];
        cnt_n = cnt_u;
        if (upd_taken) begin
            if (cnt_u != 2'b11) begin
                cnt_n = cnt_u + 2'd1;
            end
        end else begin
            if (cnt_u != 2'b00) begin
                cnt_n = cnt_u - 2'd1;
            end
        end
    end

    // Only the addressed entry changes; all others hold.
    always_comb begin
        cnt_d = cnt_q;
        if (upd_en) begin
            cnt_d[idx_u] = cnt_n;
        end
    end

    // Counter table; reset forces every entry to weak not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                cnt_q[i] <= CntInit;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Zero-latency lookup reads the registered (pre-update) table.
    always_comb begin
        is_br    = (ir_f[6:0] == OpBranch);
        pr_taken = is_br && cnt_q[idx_f][1];
    end

    // Sign-extended B-type immediate and next-PC select.
    always_comb begin
        b_off   = {{51{ir_f[31]}}, ir_f[31], ir_f[7],
                   ir_f[30:25], ir_f[11:8], 1'b0};
        pr_addr = pc_f + (pr_taken ? b_off : 64'd4);
    end

endmodule

// File: tb/tb_br_pred.sv
// tb_br_pred: directed and randomized checks of br_pred
// against a table-of-integers reference model.
module tb_br_pred;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc_f = '0;
    logic [31:0] ir_f = '0;
    logic        pr_taken;
    logic [63:0] pr_addr;
    logic        upd_valid = 1'b0;
    logic [63:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        stall = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt [64];
    int m_ghr = 0;

    br_pred dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_f     (pc_f),
        .ir_f     (ir_f),
        .pr_taken (pr_taken),
        .pr_addr  (pr_addr),
        .upd_valid(upd_valid),
        .upd_pc   (upd_pc),
        .upd_taken(upd_taken),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(logic [2:0] f3, logic [12:0] off);
        return {off[12], off[10:5], 5'd2, 5'd1, f3,
                off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic int m_idx(logic [63:0] pc);
        int i;
        i = int'((pc >> 2) & 64'd63);
`ifdef BR_PRED_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    function automatic logic m_pred(logic [63:0] pc, logic [31:0] ir);
        return (ir[6:0] == 7'h63) && (m_cnt[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [63:0] m_addr(logic [63:0] pc, logic [31:0] ir);
        longint off;
        if (!m_pred(pc, ir)) return pc + 64'd4;
        off = longint'(ir[11:8]) * 2 + longint'(ir[30:25]) * 32
            + longint'(ir[7]) * 2048 - longint'(ir[31]) * 4096;
        return pc + off;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        m_ghr = 0;
    endtask

    task automatic m_update(logic [63:0] pc, logic t);
        int i;
        i = m_idx(pc);
        if (t) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        else   m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        m_ghr = ((m_ghr << 1) | int'(t)) & 63;
    endtask

    task automatic step();
        if (rst_n && upd_valid && !stall) m_update(upd_pc, upd_taken);
        @(posedge clk);
        #1;
    endtask

    task automatic upd(logic [63:0] pc, logic t);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = t;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic look(logic [63:0] pc, logic [31:0] ir);
        pc_f = pc;
        ir_f = ir;
        #1;
    endtask

    task automatic do_reset();
        upd_valid = 1'b0;
        stall     = 1'b0;
        #2;
        rst_n = 1'b0;
        m_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [63:0] pc;
        logic [31:0] ir;
        rst_n = 1'b0;
        m_clear();
        look(64'h1000, enc_b(3'b000, 13'd16));
        n_cmp++;
        if (pr_taken !== 1'b0 || pr_addr !== 64'h1004) begin
            n_bad++;
            $display("FAIL reset_beq: got %b/%h want 0/1004", pr_taken, pr_addr);
        end
        for (int k = 0; k < 8; k++) begin
            pc = {$urandom, $urandom};
            ir = $urandom;
            ir[6:0] = 7'h63;
            look(pc, ir);
            n_cmp++;
            if (pr_taken !== 1'b0 || pr_addr !== pc + 64'd4) begin
                n_bad++;
                $display("FAIL reset_rand: pc %h got %b/%h want 0/%h",
                         pc, pr_taken, pr_addr, pc + 64'd4);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

`ifndef BR_PRED_GSHARE_EN
    task automatic test_training();
        logic [31:0] beq;
        beq = enc_b(3'b000, 13'd16);
        do_reset();
        upd(64'h1000, 1'b1);
        upd(64'h1000, 1'b1);
        look(64'h1000, beq);
        n_cmp++;
        if (pr_taken !== 1'b1 || pr_addr !== 64'h1010) begin
            n_bad++;
            $display("FAIL train_2t: got %b/%h want 1/1010", pr_taken, pr_addr);
        end
        for (int k = 0; k < 5; k++) upd(64'h1000, 1'b1);
        upd(64'h1000, 1'b0);
        look(64'h1000, beq);
        n_cmp++;
        if (pr_taken !== 1'b1 || pr_addr !== 64'h1010) begin
            n_bad++;
            $display("FAIL train_sat_1nt: got %b/%h want 1/1010", pr_taken, pr_addr);
        end
        upd(64'h1000, 1'b0);
        upd(64'h1000, 1'b0);
        look(64'h1000, beq);
        n_cmp++;
        if (pr_taken !== 1'b0 || pr_addr !== 64'h1004) begin
            n_bad++;
            $display("FAIL train_3nt: got %b/%h want 0/1004", pr_taken, pr_addr);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        pc_f      = 64'h1000;
        ir_f      = enc_b(3'b000, 13'd16);
        upd_valid = 1'b1;
        upd_pc    = 64'h1000;
        upd_taken = 1'b1;
        #1;
        n_cmp++;
        if (pr_taken !== 1'b0 || pr_addr !== 64'h1004) begin
            n_bad++;
            $display("FAIL bypass_same: got %b/%h want 0/1004", pr_taken, pr_addr);
        end
        step();
        upd_valid = 1'b0;
        #1;
        n_cmp++;
        if (pr_taken !== 1'b1 || pr_addr !== 64'h1010) begin
            n_bad++;
            $display("FAIL bypass_next: got %b/%h want 1/1010", pr_taken, pr_addr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] beq;
        beq = enc_b(3'b000, 13'd16);
        do_reset();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) upd(64'h1000, 1'b1);
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            upd_pc    = 64'h1000;
            upd_taken = 1'b1;
            step();
        end
        look(64'h1000, beq);
        n_cmp++;
        if (pr_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold: got %b want 0", pr_taken);
        end
        upd(64'h1000, 1'b0);
        upd(64'h1000, 1'b1);
        look(64'h1000, beq);
        n_cmp++;
        if (pr_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_nt_t: got %b want 0", pr_taken);
        end
    endtask

    task automatic test_alias();
        logic [31:0] beq;
        beq = enc_b(3'b000, 13'd16);
        do_reset();
        upd(64'h1100, 1'b1);
        look(64'h1000, beq);
        n_cmp++;
        if (pr_taken !== 1'b1 || pr_addr !== 64'h1010) begin
            n_bad++;
            $display("FAIL alias_1100: got %b/%h want 1/1010", pr_taken, pr_addr);
        end
        do_reset();
        upd(64'h1004, 1'b1);
        look(64'h1000, beq);
        n_cmp++;
        if (pr_taken !== 1'b0 || pr_addr !== 64'h1004) begin
            n_bad++;
            $display("FAIL alias_1004_idx0: got %b/%h want 0/1004", pr_taken, pr_addr);
        end
        look(64'h1004, beq);
        n_cmp++;
        if (pr_taken !== 1'b1 || pr_addr !== 64'h1014) begin
            n_bad++;
            $display("FAIL alias_1004_idx1: got %b/%h want 1/1014", pr_taken, pr_addr);
        end
    endtask

    task automatic test_nonbranch_wrap();
        do_reset();
        upd(64'h1000, 1'b1);
        upd(64'h1000, 1'b1);
        look(64'h1000, 32'h0100006F);
        n_cmp++;
        if (pr_taken !== 1'b0 || pr_addr !== 64'h1004) begin
            n_bad++;
            $display("FAIL jal_nt: got %b/%h want 0/1004", pr_taken, pr_addr);
        end
        look(64'h1000, enc_b(3'b000, -13'sd16));
        n_cmp++;
        if (pr_taken !== 1'b1 || pr_addr !== 64'h0FF0) begin
            n_bad++;
            $display("FAIL neg_off: got %b/%h want 1/ff0", pr_taken, pr_addr);
        end
        upd(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        look(64'hFFFF_FFFF_FFFF_FFFC, enc_b(3'b001, 13'd8));
        n_cmp++;
        if (pr_taken !== 1'b1 || pr_addr !== 64'h4) begin
            n_bad++;
            $display("FAIL wrap_bne: got %b/%h want 1/4", pr_taken, pr_addr);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] beq;
        beq = enc_b(3'b000, 13'd16);
        do_reset();
        upd(64'h1000, 1'b1);
        upd(64'h1000, 1'b1);
        look(64'h1000, beq);
        upd_valid = 1'b1;
        upd_pc    = 64'h1004;
        upd_taken = 1'b1;
        #2;
        rst_n = 1'b0;
        m_clear();
        #1;
        n_cmp++;
        if (pr_taken !== 1'b0 || pr_addr !== 64'h1004) begin
            n_bad++;
            $display("FAIL rst_mid_async: got %b/%h want 0/1004", pr_taken, pr_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        upd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            look(64'h1000 + 64'(k * 4), beq);
            n_cmp++;
            if (pr_taken !== m_pred(pc_f, ir_f) || pr_addr !== m_addr(pc_f, ir_f)) begin
                n_bad++;
                $display("FAIL rst_first_upd: pc %h got %b/%h want %b/%h", pc_f,
                         pr_taken, pr_addr, m_pred(pc_f, ir_f), m_addr(pc_f, ir_f));
            end
        end
    endtask

`ifdef BR_PRED_GSHARE_EN
    task automatic test_gshare();
        logic [31:0] beq;
        logic        exp;
        int          e;
        beq = enc_b(3'b000, 13'd16);
        do_reset();
        for (int k = 0; k < 3; k++) upd(64'h1000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            look(64'h1000 + 64'(k * 4), beq);
            e   = k ^ 7;
            exp = (e == 0 || e == 1 || e == 3);
            n_cmp++;
            if (pr_taken !== exp) begin
                n_bad++;
                $display("FAIL gshare_idx%0d: got %b want %b", e, pr_taken, exp);
            end
        end
        #2;
        rst_n = 1'b0;
        m_clear();
        for (int k = 0; k < 64; k++) begin
            look(64'h1000 + 64'(k * 4), beq);
            n_cmp++;
            if (pr_taken !== 1'b0) begin
                n_bad++;
                $display("FAIL gshare_rst idx%0d: got %b want 0", k, pr_taken);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        upd(64'h1000, 1'b1);
        look(64'h1004, beq);
        n_cmp++;
        if (pr_taken !== 1'b1) begin
            n_bad++;
            $display("FAIL gshare_ghr_clr: got %b want 1", pr_taken);
        end
    endtask
`endif

    task automatic test_random();
        logic [63:0] pc;
        logic [31:0] ir;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            pc = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                 : 64'h1000 + 64'($urandom_range(0, 15) * 4);
            ir = $urandom;
            if ($urandom_range(0, 9) < 7) ir[6:0] = 7'h63;
            pc_f      = pc;
            ir_f      = ir;
            upd_valid = ($urandom_range(0, 9) < 6);
            upd_pc    = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                        : 64'h1000 + 64'($urandom_range(0, 15) * 4);
            upd_taken = ($urandom_range(0, 9) < 6);
            stall     = ($urandom_range(0, 4) == 0);
            #1;
            n_cmp++;
            if (pr_taken !== m_pred(pc, ir) || pr_addr !== m_addr(pc, ir)) begin
                n_bad++;
                $display("FAIL random #%0d: pc %h ir %h got %b/%h want %b/%h", n, pc,
                         ir, pr_taken, pr_addr, m_pred(pc, ir), m_addr(pc, ir));
            end
            step();
        end
        upd_valid = 1'b0;
        stall     = 1'b0;
    endtask

    initial begin
        test_reset();
`ifndef BR_PRED_GSHARE_EN
        test_training();
        test_bypass();
        test_stall();
        test_alias();
        test_nonbranch_wrap();
`else
        test_gshare();
`endif
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/br_pred.md
BR_PRED -- requirements
Module: br_pred

Interface
REQ-001 Parameters: none; table depth fixed at 64 entries, 2-bit saturating counters.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports, one per line: name direction width meaning.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pc_f  input  64  fetch-stage PC.
REQ-006 ir_f  input  32  fetch-stage instruction.
REQ-007 pr_taken  output  1  prediction for ir_f, consumed by the execute-stage branch unit.
REQ-008 pr_addr  output  64  predicted next PC.
REQ-009 upd_valid  input  1  resolved conditional branch present in execute.
REQ-010 upd_pc  input  64  PC of the resolved branch.
REQ-011 upd_taken  input  1  resolved outcome.
REQ-012 stall  input  1  pipeline stall; suppresses updates.

Function
REQ-013 Branch detect: ir_f[6:0] == 7'b1100011; all other opcodes SHALL give pr_taken=0.
REQ-014 Lookup index idx_f = pc_f[7:2] (XOR ghr when gshare is enabled, REQ-026).
REQ-015 pr_taken = branch && cnt[idx_f][1]; the lookup SHALL be combinational, zero-cycle latency.
REQ-016 pr_addr = pc_f + B-offset when pr_taken, else pc_f + 4. B-offset = sign-extended {ir_f[31], ir_f[7], ir_f[30:25], ir_f[11:8], 1'b0}. 64-bit modulo arithmetic; wrap-around past 2^64 is not flagged.
REQ-017 Update fires on the rising edge when upd_valid && !stall; index idx_u = upd_pc[7:2] (XOR ghr when enabled).
REQ-018 Counter transitions: taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00. States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-019 Exactly one table entry SHALL change per update; all other entries hold.
REQ-020 Simultaneous lookup and update to the same index: the lookup SHALL return the pre-update value; the new value is visible from the next cycle.
REQ-021 stall high with upd_valid high: no counter or GHR change; the update is not retained or replayed later.
REQ-022 upd_valid low: table and GHR hold.

Reset
REQ-023 While rst_n is low, all 64 counters SHALL be 2'b01 (weak not-taken) and GHR SHALL be 0, independent of clk.
REQ-024 Reset asserted mid-update SHALL override the update; the first update is accepted on the first rising edge after rst_n deasserts.
REQ-025 Outputs remain combinational during reset: pr_taken=0 for every pc_f, and pr_addr=pc_f+4.

Configuration
REQ-026 Macro BR_PRED_GSHARE_EN. Defined: a 6-bit GHR is present; idx = pc[7:2] ^ ghr for both lookup and update; on each accepted update, ghr <= {ghr[4:0], upd_taken}, and the update index uses the pre-shift GHR. Undefined: no GHR register; idx = pc[7:2]; behaviour is otherwise identical.

Verification
REQ-027 Reset: pc_f=0x1000, ir_f=BEQ offset +16 -> pr_taken=0, pr_addr=0x1004.
REQ-028 Training (gshare off): 2 taken updates at upd_pc=0x1000, then lookup of pc_f=0x1000 BEQ +16 -> pr_taken=1, pr_addr=0x1010. 5 further taken updates -> counter stays at 11. 1 not-taken update -> pr_taken stays 1. 2 more not-taken updates -> pr_taken=0.
REQ-029 Same-index bypass: counter at 01, lookup and taken update at idx 0 in the same cycle -> pr_taken=0 in that cycle and 1 in the next cycle.
REQ-030 Stall/aliasing: taken update with stall=1 -> counter unchanged at 01. Update at upd_pc=0x1100 (idx 0, aliasing 0x1000) -> the 0x1000 prediction changes. Update at 0x1004 -> idx 0 unchanged.
REQ-031 Non-branch/wrap: ir_f=JAL with counter at 11 -> pr_taken=0. pc_f=0xFFFF_FFFF_FFFF_FFFC, BNE +8 taken -> pr_addr=0x4.
REQ-032 Gshare on: 3 taken updates at 0x1000 -> ghr=6'b000111, with each update hitting idx 0, 1 and 3 in turn. Async reset pulse mid-cycle -> ghr=0 and all counters read 01 immediately.
